// File: rtl/mux_rr_arbiter_pkg.sv
// Shared definitions for the two-source round-robin arbiter:
// output-register state encoding and the default data width.
package mux_rr_arbiter_pkg;

    localparam int DEFAULT_WIDTH = 4;

    // EMPTY: data_out holds no word for downstream; FULL: it does.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_e;

    // Source index encoding used for sel and the round-robin pointer.
    localparam logic SRC0 = 1'b0;
    localparam logic SRC1 = 1'b1;

endpackage

// File: rtl/mux_rr_arbiter.sv
// Two-source round-robin arbiter feeding a single registered output slot.
//
// Handshake: every port pair is valid/ready. A transfer happens in a cycle
// where both valid and ready are high at the rising edge; valid never
// depends on ready, while ready_0/ready_1 depend combinationally on the
// source valids, ready_out and the arbiter state.
//
// The output slot accepts a new word whenever it is empty or is being
// drained in the same cycle, so back-to-back traffic sustains one word per
// cycle. When both sources request, the one not granted most recently wins.
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_0,
    input  logic [WIDTH-1:0] din_0,
    output logic             ready_0,
    input  logic             valid_1,
    input  logic [WIDTH-1:0] din_1,
    output logic             ready_1,
    input  logic             ready_out,
    output logic             valid_out,
    output logic [WIDTH-1:0] data_out,
    output logic             sel
);

    arb_state_e       state_q;
    arb_state_e       state_d;
    logic             last_q;
    logic             out_free;
    logic             grant_valid;
    logic             grant_idx;
    logic [WIDTH-1:0] din_sel;

    assign valid_out = (state_q == FULL);
    assign out_free  = !valid_out || ready_out;

    // Grant selection: a lone requester wins; on contention the pointer
    // picks the source that was not served last.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = SRC0;
        if (valid_0 && valid_1) begin
            grant_valid = 1'b1;
            grant_idx   = ~last_q;
        end else if (valid_0) begin
            grant_valid = 1'b1;
            grant_idx   = SRC0;
        end else if (valid_1) begin
            grant_valid = 1'b1;
            grant_idx   = SRC1;
        end
    end

    // Acknowledge only the granted source, only when the slot can take a
    // word, and never while reset is asserted.
    always_comb begin
        ready_0 = 1'b0;
        ready_1 = 1'b0;
        if (!reset && out_free && grant_valid) begin
            ready_0 = (grant_idx == SRC0);
            ready_1 = (grant_idx == SRC1);
        end
    end

    // 2:1 datapath selection of the granted source's word.
    always_comb begin
        din_sel = (grant_idx == SRC1) ? din_1 : din_0;
    end

    // Next-state: any grant fills the slot; a free slot with no grant empties;
    // a stalled FULL slot holds.
    always_comb begin
        state_d = state_q;
        if (out_free) begin
            if (grant_valid) begin
                state_d = FULL;
            end else begin
                state_d = EMPTY;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Output word, source index and round-robin pointer; these change only
    // when a source transfer occurs, so a stall or an idle drain holds them.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= '0;
            sel      <= SRC0;
            last_q   <= SRC1;
        end else if (out_free && grant_valid) begin
            data_out <= din_sel;
            sel      <= grant_idx;
            last_q   <= grant_idx;
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed scenarios followed by randomized
// traffic, all compared each cycle against a transaction-level model.
module tb_mux_rr_arbiter;

    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic         valid_0;
    logic [W-1:0] din_0;
    logic         ready_0;
    logic         valid_1;
    logic [W-1:0] din_1;
    logic         ready_1;
    logic         ready_out;
    logic         valid_out;
    logic [W-1:0] data_out;
    logic         sel;

    int n_cmp;
    int n_mis;

    // Reference model state: the word sitting in the output slot, and which
    // source is owed the next turn when both request.
    logic         m_valid;
    logic [W-1:0] m_data;
    logic         m_sel;
    logic         m_owed;
    logic         m_rdy [2];
    int           wait_xfers [2];

    mux_rr_arbiter #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_0   (valid_0),
        .din_0     (din_0),
        .ready_0   (ready_0),
        .valid_1   (valid_1),
        .din_1     (din_1),
        .ready_1   (ready_1),
        .ready_out (ready_out),
        .valid_out (valid_out),
        .data_out  (data_out),
        .sel       (sel)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Work out which source the model would acknowledge this cycle.
    task automatic model_ready();
        logic free;
        int   who;
        free     = !m_valid || ready_out;
        m_rdy[0] = 1'b0;
        m_rdy[1] = 1'b0;
        who      = -1;
        if (valid_0 && valid_1) who = int'(m_owed);
        else if (valid_0)       who = 0;
        else if (valid_1)       who = 1;
        if (!reset && free && who >= 0) m_rdy[who] = 1'b1;
    endtask

    // Advance the model across one rising edge.
    task automatic model_edge();
        logic free;
        logic out_xfer;
        free     = !m_valid || ready_out;
        out_xfer = m_valid && ready_out;
        if (reset) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_sel   = 1'b0;
            m_owed  = 1'b0;
            wait_xfers[0] = 0;
            wait_xfers[1] = 0;
            return;
        end
        for (int s = 0; s < 2; s++) begin
            if (m_rdy[s]) wait_xfers[s] = 0;
            else if (out_xfer && (s == 0 ? valid_0 : valid_1)) wait_xfers[s]++;
        end
        if (m_rdy[0] || m_rdy[1]) begin
            m_valid = 1'b1;
            m_data  = m_rdy[0] ? din_0 : din_1;
            m_sel   = m_rdy[1];
            m_owed  = m_rdy[0];
        end else if (free) begin
            m_valid = 1'b0;
        end
    endtask

    // One clock: compare all outputs at the falling edge, then step the
    // model at the rising edge. Inputs are changed by the caller afterwards.
    task automatic cycle(input string tag);
        @(negedge clk);
        model_ready();
        chk({tag, ".ready_0"}, 32'(ready_0), 32'(m_rdy[0]));
        chk({tag, ".ready_1"}, 32'(ready_1), 32'(m_rdy[1]));
        chk({tag, ".valid_out"}, 32'(valid_out), 32'(m_valid));
        chk({tag, ".data_out"}, 32'(data_out), 32'(m_data));
        chk({tag, ".sel"}, 32'(sel), 32'(m_sel));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic v0, input logic [W-1:0] d0,
                         input logic v1, input logic [W-1:0] d1, input logic ro);
        valid_0   = v0;
        din_0     = d0;
        valid_1   = v1;
        din_1     = d1;
        ready_out = ro;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle("reset");
        cycle("reset");
        reset = 1'b0;
    endtask

    logic [W-1:0] seq_data [4];
    logic         seq_sel  [4];
    logic         pend [2];

    initial begin
        n_cmp = 0;
        n_mis = 0;
        m_valid = 1'b0;
        m_data  = '0;
        m_sel   = 1'b0;
        m_owed  = 1'b0;
        wait_xfers[0] = 0;
        wait_xfers[1] = 0;
        reset = 1'b1;
        drive(1'b1, 4'hF, 1'b1, 4'hF, 1'b1);
        #1;

        // Reset with both sources requesting: no acknowledges, slot cleared.
        do_reset();
        chk("rst.valid_out", 32'(valid_out), 32'd0);
        chk("rst.data_out", 32'(data_out), 32'd0);
        chk("rst.sel", 32'(sel), 32'd0);

        // Single word from source 0.
        drive(1'b1, 4'b1010, 1'b0, 4'b0000, 1'b1);
        cycle("single");
        drive(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1);
        chk("single.data_out", 32'(data_out), 32'hA);
        chk("single.sel", 32'(sel), 32'd0);
        chk("single.valid_out", 32'(valid_out), 32'd1);
        // Idle drain: valid drops, word holds.
        cycle("drain");
        chk("drain.valid_out", 32'(valid_out), 32'd0);
        chk("drain.data_out", 32'(data_out), 32'hA);

        // Contention alternates starting with source 0.
        do_reset();
        seq_data = '{4'b1010, 4'b0110, 4'b1010, 4'b0110};
        seq_sel  = '{1'b0, 1'b1, 1'b0, 1'b1};
        drive(1'b1, 4'b1010, 1'b1, 4'b0110, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle("rr");
            chk($sformatf("rr%0d.data_out", i), 32'(data_out), 32'(seq_data[i]));
            chk($sformatf("rr%0d.sel", i), 32'(sel), 32'(seq_sel[i]));
        end

        // Stall holding 0110 from source 1, then release goes to source 0.
        ready_out = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle("stall");
            chk("stall.data_out", 32'(data_out), 32'b0110);
            chk("stall.sel", 32'(sel), 32'd1);
        end
        ready_out = 1'b1;
        cycle("release");
        chk("release.data_out", 32'(data_out), 32'b1010);
        chk("release.sel", 32'(sel), 32'd0);

        // Reset while full and stalled discards the word.
        do_reset();
        drive(1'b1, 4'b0001, 1'b0, 4'b0000, 1'b1);
        cycle("fill");
        drive(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);
        cycle("held");
        chk("held.data_out", 32'(data_out), 32'b0001);
        reset = 1'b1;
        cycle("midrst");
        chk("midrst.valid_out", 32'(valid_out), 32'd0);
        chk("midrst.data_out", 32'(data_out), 32'd0);
        chk("midrst.sel", 32'(sel), 32'd0);
        reset = 1'b0;
        drive(1'b1, 4'b0011, 1'b1, 4'b1100, 1'b1);
        cycle("post");
        chk("post.sel", 32'(sel), 32'd0);
        chk("post.data_out", 32'(data_out), 32'b0011);

        // Randomized traffic: a source keeps valid until it is accepted, but
        // its data may wander while it waits; occasional resets.
        pend[0] = valid_0;
        pend[1] = valid_1;
        for (int n = 0; n < 400; n++) begin
            if (reset) begin
                pend[0] = 1'b0;
                pend[1] = 1'b0;
            end else begin
                if (m_rdy[0]) pend[0] = 1'b0;
                if (m_rdy[1]) pend[1] = 1'b0;
            end
            if (!pend[0]) pend[0] = ($urandom_range(0, 2) != 0);
            if (!pend[1]) pend[1] = ($urandom_range(0, 2) != 0);
            drive(pend[0], W'($urandom), pend[1], W'($urandom),
                  ($urandom_range(0, 3) != 0));
            reset = ($urandom_range(0, 63) == 0);
            cycle("rand");
            chk("rand.wait0", 32'(wait_xfers[0] <= 2), 32'd1);
            chk("rand.wait1", 32'(wait_xfers[1] <= 2), 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
